// File: rtl/pulse_scheduler_if.sv
// rtl/pulse_scheduler_if.sv - requester/channel bundle between trigger logic and pulse_scheduler
interface pulse_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 16
) ();
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*LEN_W-1:0]   len;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         done;
   logic                       pulse;
   logic [$clog2(NUM_REQ)-1:0] owner;
   logic                       busy;

   modport master (output req, len, input grant, done, pulse, owner, busy);
   modport slave  (input req, len, output grant, done, pulse, owner, busy);
endinterface

// File: rtl/pulse_scheduler.sv
// rtl/pulse_scheduler.sv - round-robin owner of one shared pulse line, exact-length pulses
// Define PULSE_SCHED_GAP_EN to force GAP_CYCLES low cycles after every pulse.
module pulse_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int LEN_W      = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   pulse_scheduler_if.slave  bus
);
   localparam int OW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0) begin : g_bad_cfg
      $error("pulse_scheduler: unsupported NUM_REQ or GAP_CYCLES");
   end

`ifdef PULSE_SCHED_GAP_EN
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   logic [GW-1:0] gcnt;
`else
   typedef enum logic [1:0] {S_IDLE, S_PULSE} state_t;
`endif

   state_t              state;
   logic [LEN_W-1:0]    cnt;
   logic [OW-1:0]       last;
   logic [OW-1:0]       owner_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  done_q;
   logic                pulse_q;
   logic                busy_q;

   logic [OW-1:0]       winner;
   logic [OW-1:0]       idx_s;
   logic                found;
   logic [LEN_W-1:0]    win_len;
   int                  idx;

   // Search starts just past the previous owner so it becomes lowest priority.
   always_comb begin
      winner = last;
      found  = 1'b0;
      idx    = 0;
      idx_s  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_s = OW'(idx);
         if (!found && bus.req[idx_s]) begin
            winner = idx_s;
            found  = 1'b1;
         end
      end
      win_len = bus.len[int'(winner)*LEN_W +: LEN_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         last    <= OW'(NUM_REQ-1);
         owner_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef PULSE_SCHED_GAP_EN
         gcnt    <= '0;
`endif
      end else begin
         done_q <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  // Loading len-1 makes the high time exactly len; zero clamps to one.
                  cnt     <= (win_len == '0) ? '0 : win_len - 1'b1;
                  grant_q <= ONE << winner;
                  owner_q <= winner;
                  pulse_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= S_PULSE;
               end
            end
            S_PULSE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  pulse_q <= 1'b0;
                  grant_q <= '0;
                  done_q  <= ONE << owner_q;
                  last    <= owner_q;
`ifdef PULSE_SCHED_GAP_EN
                  if (GAP_CYCLES == 0) begin
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     gcnt  <= GW'(GAP_CYCLES - 1);
                     state <= S_GAP;
                  end
`else
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
`endif
               end
            end
`ifdef PULSE_SCHED_GAP_EN
            S_GAP: begin
               if (gcnt == '0) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  gcnt <= gcnt - 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.pulse = pulse_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_pulse_scheduler.sv
// tb/tb_pulse_scheduler.sv - scoreboard bench for pulse_scheduler
module tb_pulse_scheduler;
   localparam int N   = 4;
   localparam int LW  = 16;
   localparam int GAP = 2;
`ifdef PULSE_SCHED_GAP_EN
   localparam int LOW = GAP + 1;
`else
   localparam int LOW = 1;
`endif
   localparam int BOUND = 70000;

   typedef struct {int owner; int width; int low;} exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   pulse_scheduler_if #(.NUM_REQ(N), .LEN_W(LW)) bus ();
   pulse_scheduler #(.NUM_REQ(N), .LEN_W(LW), .GAP_CYCLES(GAP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int o, input int w, input int l);
      exp_t e;
      e.owner = o; e.width = w; e.low = l;
      exp_q.push_back(e);
   endtask

   task automatic set_len(input int i, input int v);
      bus.len[i*LW +: LW] = LW'(v);
   endtask

   task automatic wait_grant(input int i, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.grant[i] && n < BOUND);
      check({name, "_grant_seen"}, bus.grant[i], 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
   endtask

   // Monitor: measures each pulse and its preceding low time, pops on done.
   int          wid, low, low_before, last_wid, own_seen;
   logic [N-1:0] gr_seen;
   logic        prev_p, have_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_p = 1'b0; have_prev = 1'b0; wid = 0; low = 0; low_before = -1;
      end else begin
         if (bus.pulse && !prev_p) begin
            low_before = have_prev ? low : -1;
            wid = 1; own_seen = int'(bus.owner); gr_seen = bus.grant;
         end else if (bus.pulse) begin
            wid++;
         end
         if (!bus.pulse && prev_p) begin
            last_wid = wid; have_prev = 1'b1; low = 1;
         end else if (!bus.pulse) begin
            low++;
         end
         if (bus.done != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", bus.done, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_vector", bus.done, 1 << e.owner);
               check("done_after_fall", prev_p, 1);
               check("grant_low_at_done", bus.grant, 0);
               check("pulse_width", last_wid, e.width);
               check("owner", own_seen, e.owner);
               check("grant_onehot", gr_seen, 1 << e.owner);
               if (e.low != 0) check("low_time", low_before, e.low);
            end
         end
         prev_p = bus.pulse;
      end
   end

   initial begin
      bus.req = '0;
      bus.len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pulse", bus.pulse, 0);
      check("rst_grant", bus.grant, 0);
      check("rst_done",  bus.done, 0);
      check("rst_owner", bus.owner, 0);
      check("rst_busy",  bus.busy, 0);
      rst_n = 1'b1;

      // Single request, one-cycle latency
      @(posedge clk); #1;
      set_len(0, 3);
      bus.req = 4'b0001;
      push(0, 3, 0);
      @(negedge clk);
      check("lat_before_edge", bus.pulse, 0);
      @(negedge clk);
      check("lat_pulse", bus.pulse, 1);
      check("lat_grant", bus.grant, 4'b0001);
      check("lat_busy", bus.busy, 1);
      bus.req = '0;
      drain("single");

      // Contention, all four held
      pulse_reset();
      set_len(0, 2); set_len(1, 3); set_len(2, 4); set_len(3, 5);
      bus.req = 4'b1111;
      push(0, 2, 0); push(1, 3, LOW); push(2, 4, LOW); push(3, 5, LOW); push(0, 2, LOW);
      wait_grant(3, "cont3");
      wait_grant(0, "cont0b");
      bus.req = '0;
      drain("contention");

      // Committed pulse: req and len change mid-pulse
      set_len(1, 10);
      bus.req = 4'b0010;
      push(1, 10, 0);
      wait_grant(1, "commit");
      @(negedge clk);
      bus.req = '0;
      set_len(1, 1);
      drain("commit");

      // Clamp len=0
      set_len(2, 0);
      bus.req = 4'b0100;
      push(2, 1, 0);
      wait_grant(2, "clamp");
      bus.req = '0;
      drain("clamp");

      // Maximum length, no wrap
      set_len(3, 16'hFFFF);
      bus.req = 4'b1000;
      push(3, 65535, 0);
      wait_grant(3, "maxlen");
      bus.req = '0;
      drain("maxlen");

      // Reset in pulse cycle 3
      set_len(1, 10);
      bus.req = 4'b0010;
      wait_grant(1, "midrst");
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_pulse", bus.pulse, 0);
      check("midrst_grant", bus.grant, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      @(negedge clk);
      check("midrst_done2", bus.done, 0);
      #1 rst_n = 1'b1;
      set_len(0, 2); set_len(1, 2);
      bus.req = 4'b0011;
      push(0, 2, 0); push(1, 2, LOW);
      wait_grant(0, "postrst0");
      bus.req[0] = 1'b0;
      wait_grant(1, "postrst1");
      bus.req[1] = 1'b0;
      drain("postrst");

      // Fair re-request: req0 held with req2
      pulse_reset();
      set_len(0, 1); set_len(2, 2);
      bus.req = 4'b0101;
      push(0, 1, 0); push(2, 2, LOW); push(0, 1, LOW); push(2, 2, LOW);
      wait_grant(0, "fair0a");
      wait_grant(2, "fair2a");
      wait_grant(0, "fair0b");
      wait_grant(2, "fair2b");
      bus.req = '0;
      drain("fair");

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
